// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between the core's execute stage and muldiv_seq.
// The core drives the master side and the sequencer drives the slave side.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      fn3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] result;
    logic            done;
    logic            busy;
    logic            stall;
    modport master (output start, fn3, rs1_data, rs2_data, input result, done, busy, stall);
    modport slave (input start, fn3, rs1_data, rs2_data, output result, done, busy, stall);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide, one shift/add or shift/subtract step per clock.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU/REM/REMU finish in one cycle with 0.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t            state_q, state_d;
    logic [2:0]        fn3_q, fn3_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d, result_q, result_d;
    logic              sa, sb, an, bn;
    logic [XLEN-1:0]   ma, mb, fin;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] mstep, step, prod;
`ifdef MULDIV_DIV_EN
    logic              rneg_q, rneg_d, ge, fast;
    logic [XLEN:0]     pr;
    logic [XLEN-1:0]   q, r, fast_res;
    logic [2*XLEN-1:0] dstep;
`endif
    assign sa = (bus.fn3 == 3'b001) | (bus.fn3 == 3'b010) | (bus.fn3[2] & ~bus.fn3[0]);
    assign sb = (bus.fn3 == 3'b001) | (bus.fn3[2] & ~bus.fn3[0]);
    assign an = sa & bus.rs1_data[XLEN-1];
    assign bn = sb & bus.rs2_data[XLEN-1];
    assign ma = an ? -bus.rs1_data : bus.rs1_data;
    assign mb = bn ? -bus.rs2_data : bus.rs2_data;
    // acc holds {partial product, remaining multiplier bits}; the add result shifts right into it
    assign sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mstep = {sum, acc_q[XLEN-1:1]};
    assign prod  = neg_q ? -step : step;
`ifdef MULDIV_DIV_EN
    // acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}
    assign pr       = acc_q[2*XLEN-1:XLEN-1];
    assign ge       = pr >= {1'b0, opb_q};
    assign dstep    = {ge ? pr[XLEN-1:0] - opb_q : pr[XLEN-1:0], acc_q[XLEN-2:0], ge};
    assign step     = fn3_q[2] ? dstep : mstep;
    assign q        = step[XLEN-1:0];
    assign r        = step[2*XLEN-1:XLEN];
    assign fin      = !fn3_q[2] ? (fn3_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                    : fn3_q[1] ? (rneg_q ? -r : r) : (neg_q ? -q : q);
    assign fast     = bus.fn3[2] & ((bus.rs2_data == '0) | (~bus.fn3[0]
                    & (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.rs2_data)));
    assign fast_res = (bus.rs2_data == '0) ? (bus.fn3[1] ? bus.rs1_data : '1)
                    : (bus.fn3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
`else
    assign step = mstep;
    assign fin  = fn3_q[2] ? '0 : (fn3_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
`endif
    always_comb begin
        state_d  = state_q;
        fn3_d    = fn3_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        result_d = result_q;
`ifdef MULDIV_DIV_EN
        rneg_d   = rneg_q;
`endif
        case (state_q)
            IDLE: if (bus.start) begin
                fn3_d    = bus.fn3;
                neg_d    = an ^ bn;
                cnt_d    = CW'(XLEN - 1);
                acc_d    = {{XLEN{1'b0}}, bus.fn3[2] ? ma : mb};
                opb_d    = bus.fn3[2] ? mb : ma;
`ifdef MULDIV_DIV_EN
                rneg_d   = an;
                state_d  = fast ? DONE : CALC;
                result_d = fast ? fast_res : result_q;
`else
                state_d  = bus.fn3[2] ? DONE : CALC;
                result_d = bus.fn3[2] ? '0 : result_q;
`endif
            end
            CALC: begin
                acc_d    = step;
                cnt_d    = cnt_q - 1'b1;
                state_d  = (cnt_q == '0) ? DONE : CALC;
                result_d = (cnt_q == '0) ? fin : result_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            fn3_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
`ifdef MULDIV_DIV_EN
            rneg_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            fn3_q    <= fn3_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            result_q <= result_d;
`ifdef MULDIV_DIV_EN
            rneg_q   <= rneg_d;
`endif
        end
    end
    assign bus.result = result_q;
    assign bus.done   = state_q == DONE;
    assign bus.busy   = state_q != IDLE;
    assign bus.stall  = (state_q == IDLE && bus.start) || state_q == CALC;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table vectors, corner-case sequences and random ops against an arithmetic model.
module tb_muldiv_seq;
    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
        string       nm;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_n = 0;
    int   total_n = 0;
    vec_t tbl[$];
    muldiv_seq_if #(.XLEN(32)) bus ();
    muldiv_seq #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'b0, a});
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        logic [31:0] res;
        case (f)
            3'd0: begin p = ua * ub; res = p[31:0]; end
            3'd1: begin p = sa * sb; res = p[63:32]; end
            3'd2: begin p = sa * ub; res = p[63:32]; end
            3'd3: begin p = ua * ub; res = p[63:32]; end
            3'd4: begin p = (b == 0) ? 64'hFFFFFFFF : sa / sb; res = p[31:0]; end
            3'd5: begin p = (b == 0) ? 64'hFFFFFFFF : ua / ub; res = p[31:0]; end
            3'd6: begin p = (b == 0) ? ua : sa % sb; res = p[31:0]; end
            default: begin p = (b == 0) ? ua : ua % ub; res = p[31:0]; end
        endcase
`ifndef MULDIV_DIV_EN
        if (f[2]) res = 32'h0;
`endif
        return res;
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
        if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
        return 33;
`else
        return f[2] ? 1 : 33;
`endif
    endfunction

    // Called on a negedge; returns on the negedge of the cycle after done.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input int exp_l, input string nm);
        int   lat = 0;
        logic flow_ok = 1'b1;
        bus.start = 1'b1; bus.fn3 = f; bus.rs1_data = a; bus.rs2_data = b;
        #1 chk({nm, " stall_at_start"}, 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1 bus.start = 1'b0; bus.fn3 = 3'($urandom); bus.rs1_data = $urandom; bus.rs2_data = $urandom;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.done) break;
            if (!bus.stall || !bus.busy) flow_ok = 1'b0;
        end
        chk({nm, " latency"}, 32'(lat), 32'(exp_l));
        chk({nm, " result"}, bus.result, exp_r);
        chk({nm, " stall_busy_in_calc"}, 32'(flow_ok), 32'd1);
        chk({nm, " stall_low_at_done"}, 32'(bus.stall), 32'd0);
        @(negedge clk);
        chk({nm, " done_one_cycle"}, 32'({bus.done, bus.busy}), 32'd0);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        int          lat, dcnt;
        bus.start = 1'b0; bus.fn3 = '0; bus.rs1_data = '0; bus.rs2_data = '0;
        tbl.push_back('{3'd0, 32'd7,          32'd6,          32'h0000002A, 33, "MUL 7x6"});
        tbl.push_back('{3'd1, 32'h80000000,   32'h80000000,   32'h40000000, 33, "MULH min*min"});
        tbl.push_back('{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 33, "MULHU max*max"});
        tbl.push_back('{3'd2, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF, 33, "MULHSU -1x2"});
        tbl.push_back('{3'd0, 32'd3,          32'd4,          32'd12,       33, "MUL 3x4"});
        tbl.push_back('{3'd4, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 33, "DIV -7/2"});
        tbl.push_back('{3'd6, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF, 33, "REM -7/2"});
        tbl.push_back('{3'd5, 32'd100,        32'd7,          32'd14,       33, "DIVU 100/7"});
        tbl.push_back('{3'd7, 32'd100,        32'd7,          32'd2,        33, "REMU 100/7"});
        tbl.push_back('{3'd4, 32'd10,         32'd2,          32'd5,        33, "DIV 10/2"});
        tbl.push_back('{3'd5, 32'd5,          32'd0,          32'hFFFFFFFF, 1,  "DIVU 5/0"});
        tbl.push_back('{3'd6, 32'd5,          32'd0,          32'd5,        1,  "REM 5/0"});
        tbl.push_back('{3'd4, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1,  "DIV ovf"});
        tbl.push_back('{3'd6, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 1,  "REM ovf"});
        #1;
        chk("reset result", bus.result, 32'd0);
        chk("reset done_busy_stall", 32'({bus.done, bus.busy, bus.stall}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        foreach (tbl[i]) begin
`ifndef MULDIV_DIV_EN
            if (tbl[i].f[2]) begin tbl[i].r = 32'd0; tbl[i].lat = 1; end
`endif
            do_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].lat, tbl[i].nm);
        end
        // A start during CALC must neither disturb the running op nor be queued.
        bus.start = 1'b1; bus.fn3 = 3'd0; bus.rs1_data = 32'd7; bus.rs2_data = 32'd6;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.start = 1'b1; bus.fn3 = 3'd3; bus.rs1_data = 32'hFFFFFFFF; bus.rs2_data = 32'hFFFFFFFF;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 10;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.done) break;
        end
        chk("ignored_start latency", 32'(lat), 32'd33);
        chk("ignored_start result", bus.result, 32'h0000002A);
        dcnt = 0;
        repeat (40) begin @(negedge clk); if (bus.done) dcnt++; end
        chk("ignored_start not_queued", 32'(dcnt), 32'd0);
        // Reset in the middle of a long operation.
`ifdef MULDIV_DIV_EN
        f = 3'd4;
`else
        f = 3'd0;
`endif
        bus.start = 1'b1; bus.fn3 = f; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset result", bus.result, 32'd0);
        chk("midreset done_stall", 32'({bus.done, bus.stall}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (40) begin @(negedge clk); if (bus.done) dcnt++; end
        chk("midreset no_done", 32'(dcnt), 32'd0);
        // Random operations against the arithmetic model.
        for (int n = 0; n < 60; n++) begin
            f = 3'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) == 0) ? $urandom_range(1, 300) : $urandom;
            if ($urandom_range(0, 15) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            do_op(f, a, b, ref_res(f, a, b), ref_lat(f, a, b), $sformatf("rand%0d fn3=%0d", n, f));
        end
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
